// File: rtl/disp_conf_arbiter.sv
// Merges the left/right disparity+confidence streams into one tagged stream,
// granting one source for a whole decimated line before rearbitrating.
module disp_conf_arbiter #(
  parameter int unsigned disp_bits       = 5,
  parameter int unsigned line_words      = 320,
  parameter int unsigned lines_per_frame = 240
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mode,
  input  logic [disp_bits+7:0]   in0_data,
  input  logic                   in0_valid,
  output logic                   in0_ready,
  input  logic [disp_bits+7:0]   in1_data,
  input  logic                   in1_valid,
  output logic                   in1_ready,
  output logic [disp_bits+7:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_src,
  output logic                   out_sol,
  output logic                   out_eol,
  output logic                   out_sof,
  output logic                   frame_done
);

  localparam int unsigned word_cnt_w = $clog2(line_words);
  localparam int unsigned line_cnt_w = $clog2(lines_per_frame + 1);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    ptr, ptr_nxt;
  logic [word_cnt_w-1:0]   word_cnt, word_cnt_nxt;
  logic [line_cnt_w-1:0]   line_cnt0, line_cnt0_nxt;
  logic [line_cnt_w-1:0]   line_cnt1, line_cnt1_nxt;
  logic                    frame_done_nxt;

  logic done0, done1;
  logic first_word, last_word;
  logic gsel, sel_valid, sel_line0;
  logic elig0, elig1, ptr_elig, oth_elig, ptr_free;

  assign done0      = (line_cnt0 == line_cnt_w'(lines_per_frame));
  assign done1      = (line_cnt1 == line_cnt_w'(lines_per_frame));
  assign first_word = (word_cnt == '0);
  assign last_word  = (word_cnt == word_cnt_w'(line_words - 1));
  assign gsel       = (state == GRANT1);
  assign sel_valid  = gsel ? in1_valid : in0_valid;
  assign sel_line0  = gsel ? (line_cnt1 == '0) : (line_cnt0 == '0);

  // Work-conserving eligibility only counts sources that have data now.
  assign elig0    = in0_valid && !done0;
  assign elig1    = in1_valid && !done1;
  assign ptr_elig = ptr ? elig1 : elig0;
  assign oth_elig = ptr ? elig0 : elig1;
  assign ptr_free = ptr ? !done1 : !done0;

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB;
      ptr        <= 1'b0;
      word_cnt   <= '0;
      line_cnt0  <= '0;
      line_cnt1  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      word_cnt   <= word_cnt_nxt;
      line_cnt0  <= line_cnt0_nxt;
      line_cnt1  <= line_cnt1_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Arbitration, zero-latency data path and line/frame tagging
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    word_cnt_nxt   = word_cnt;
    line_cnt0_nxt  = line_cnt0;
    line_cnt1_nxt  = line_cnt1;
    frame_done_nxt = 1'b0;
    in0_ready      = 1'b0;
    in1_ready      = 1'b0;
    out_data       = '0;
    out_valid      = 1'b0;
    out_src        = 1'b0;
    out_sol        = 1'b0;
    out_eol        = 1'b0;
    out_sof        = 1'b0;

    case (state)
      ARB: begin
        if (done0 && done1) begin
          frame_done_nxt = 1'b1;
          line_cnt0_nxt  = '0;
          line_cnt1_nxt  = '0;
          ptr_nxt        = 1'b0;
        end else if (!mode) begin
          // Strict alternation: at least one source is not done here.
          if (ptr_free) state_nxt = ptr ? GRANT1 : GRANT0;
          else          state_nxt = ptr ? GRANT0 : GRANT1;
        end else begin
          if (ptr_elig)      state_nxt = ptr ? GRANT1 : GRANT0;
          else if (oth_elig) state_nxt = ptr ? GRANT0 : GRANT1;
        end
      end

      GRANT0, GRANT1: begin
        out_data  = gsel ? in1_data : in0_data;
        out_valid = sel_valid;
        in0_ready = !gsel && out_ready;
        in1_ready = gsel && out_ready;
        out_src   = gsel;
        out_sol   = first_word;
        out_eol   = last_word;
        out_sof   = first_word && sel_line0;
        if (sel_valid && out_ready) begin
          if (last_word) begin
            word_cnt_nxt = '0;
            state_nxt    = ARB;
            ptr_nxt      = !gsel;
            if (gsel) line_cnt1_nxt = line_cnt1 + line_cnt_w'(1);
            else      line_cnt0_nxt = line_cnt0 + line_cnt_w'(1);
          end else begin
            word_cnt_nxt = word_cnt + word_cnt_w'(1);
          end
        end
      end

      default: state_nxt = ARB;
    endcase
  end

endmodule

// File: tb/tb_disp_conf_arbiter.sv
// Scoreboard bench for disp_conf_arbiter: directed line/frame sequences with
// hand-ordered expected beats, checked by an independent output monitor.
module tb_disp_conf_arbiter;

  localparam int unsigned DB  = 5;
  localparam int unsigned LW  = 4;
  localparam int unsigned LPF = 2;
  localparam int unsigned DW  = DB + 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mode;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic          in0_valid, in0_ready, in1_valid, in1_ready;
  logic          out_valid, out_ready, out_src, out_sol, out_eol, out_sof;
  logic          frame_done;

  typedef struct packed {
    logic          fd;
    logic [DW-1:0] data;
    logic          src;
    logic          sol;
    logic          eol;
    logic          sof;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            errors = 0;
  int            checks = 0;
  bit            en0, en1, bp, hs0, hs1, stalled;
  logic [DW+3:0] held;

  disp_conf_arbiter #(.disp_bits(DB), .line_words(LW), .lines_per_frame(LPF)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [DW-1:0] word_of(int s, int ln, int tag, int w);
    return DW'((tag << 6) | (s << 5) | (ln << 2) | w);
  endfunction

  task automatic src_line(int s, int ln, int tag);
    for (int w = 0; w < int'(LW); w++) begin
      if (s == 0) q0.push_back(word_of(s, ln, tag, w));
      else        q1.push_back(word_of(s, ln, tag, w));
    end
  endtask

  task automatic exp_beat(int s, int ln, int tag, int w);
    exp_t e;
    e.fd   = 1'b0;
    e.data = word_of(s, ln, tag, w);
    e.src  = (s != 0);
    e.sol  = (w == 0);
    e.eol  = (w == int'(LW) - 1);
    e.sof  = (w == 0) && (ln % int'(LPF) == 0);
    exp_q.push_back(e);
  endtask

  task automatic exp_line(int s, int ln, int tag);
    for (int w = 0; w < int'(LW); w++) exp_beat(s, ln, tag, w);
  endtask

  task automatic exp_fd();
    exp_t e;
    e    = '0;
    e.fd = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_size(int n, string name);
    int t = 0;
    while (exp_q.size() > n && t < 300) begin
      tick();
      t++;
    end
    if (exp_q.size() > n) check(name, 64'(exp_q.size()), 64'(n));
  endtask

  // Asserts reset and confirms every output drops at once, before any edge.
  task automatic do_reset(string name);
    reset_n = 1'b0;
    #1;
    check(name, 64'({out_valid, in0_ready, in1_ready, out_src, out_sol, out_eol,
                     out_sof, frame_done, out_data}), 64'(0));
    q0.delete();
    q1.delete();
    exp_q.delete();
    bp  = 1'b0;
    en0 = 1'b1;
    en1 = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Source and sink driver: pops a word after each handshake, holds otherwise.
  initial begin
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
      end
      out_ready = bp ? !out_ready : 1'b1;
      in0_valid = en0 && (q0.size() > 0);
      in1_valid = en1 && (q1.size() > 0);
      in0_data  = (q0.size() > 0) ? q0[0] : '0;
      in1_data  = (q1.size() > 0) ? q1[0] : '0;
    end
  end

  // Output monitor: scoreboard pop on each beat and each frame_done pulse.
  always @(negedge clk) begin
    exp_t e;
    hs0 = reset_n && in0_valid && in0_ready;
    hs1 = reset_n && in1_valid && in1_ready;
    if (reset_n) begin
      if (stalled && out_valid)
        check("stall_hold", 64'({out_data, out_src, out_sol, out_eol, out_sof}), 64'(held));
      stalled = out_valid && !out_ready;
      held    = {out_data, out_src, out_sol, out_eol, out_sof};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0 || exp_q[0].fd) begin
          check("extra_beat", 64'({out_src, out_data}), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({out_data, out_src, out_sol, out_eol, out_sof}),
                64'({e.data, e.src, e.sol, e.eol, e.sof}));
        end
      end
      if (frame_done) begin
        if (exp_q.size() == 0) check("frame_done", 64'(frame_done), 64'(0));
        else begin
          check("frame_done", 64'(frame_done), 64'(exp_q[0].fd));
          if (exp_q[0].fd) void'(exp_q.pop_front());
        end
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    mode    = 1'b0;
    en0 = 1'b0; en1 = 1'b0; bp = 1'b0; hs0 = 1'b0; hs1 = 1'b0; stalled = 1'b0;
    held = '0;

    // Plain strict alternation over a full frame
    do_reset("rst_t1");
    src_line(0, 0, 1); src_line(0, 1, 1); src_line(1, 0, 1); src_line(1, 1, 1);
    exp_line(0, 0, 1); exp_line(1, 0, 1); exp_line(0, 1, 1); exp_line(1, 1, 1); exp_fd();
    wait_size(0, "t1_drain");

    // Strict mode waits on an idle src1 even though src0 has data
    do_reset("rst_t2");
    en1 = 1'b0;
    src_line(0, 0, 2); src_line(0, 1, 2); src_line(1, 0, 2); src_line(1, 1, 2);
    exp_line(0, 0, 2); exp_line(1, 0, 2); exp_line(0, 1, 2); exp_line(1, 1, 2); exp_fd();
    wait_size(13, "t2_first_line");
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_idle_grant1", 64'({out_valid, in0_ready, in0_valid, out_src}), 64'(4'b0011));
      tick();
    end
    en1 = 1'b1;
    wait_size(0, "t2_drain");

    // Work-conserving: src0 takes two lines, then is done and locked out
    do_reset("rst_t3");
    mode = 1'b1;
    en1  = 1'b0;
    src_line(0, 0, 3); src_line(0, 1, 3); src_line(0, 2, 3);
    src_line(1, 0, 3); src_line(1, 1, 3);
    exp_line(0, 0, 3); exp_line(0, 1, 3); exp_line(1, 0, 3); exp_line(1, 1, 3); exp_fd();
    exp_line(0, 2, 3);
    wait_size(13, "t3_src0_lines");
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      check("t3_done_lockout", 64'({out_valid, in0_ready, in0_valid, in1_ready}), 64'(4'b0010));
      tick();
    end
    en1 = 1'b1;
    wait_size(0, "t3_drain");

    // Backpressure toggling on every cycle
    do_reset("rst_t4");
    mode = 1'b0;
    bp   = 1'b1;
    src_line(0, 0, 4); src_line(0, 1, 4); src_line(1, 0, 4); src_line(1, 1, 4);
    exp_line(0, 0, 4); exp_line(1, 0, 4); exp_line(0, 1, 4); exp_line(1, 1, 4); exp_fd();
    wait_size(0, "t4_drain");
    bp = 1'b0;

    // Reset in the middle of a src1 line restarts at src0 start-of-frame
    do_reset("rst_t5");
    src_line(0, 0, 5); src_line(1, 0, 5);
    exp_line(0, 0, 5); exp_beat(1, 0, 5, 0); exp_beat(1, 0, 5, 1);
    wait_size(0, "t5_partial");
    @(posedge clk);
    #3;
    check("t5_pre_reset", 64'({out_valid, out_src}), 64'(2'b11));
    do_reset("t5_async_reset");
    src_line(0, 0, 6); src_line(1, 0, 6);
    exp_line(0, 0, 6); exp_line(1, 0, 6);
    wait_size(0, "t5_drain");

    // Mode flips to work-conserving mid-line; takes effect at next ARB
    do_reset("rst_t6");
    mode = 1'b0;
    en1  = 1'b0;
    src_line(0, 0, 7); src_line(0, 1, 7); src_line(1, 0, 7); src_line(1, 1, 7);
    exp_line(0, 0, 7); exp_line(0, 1, 7); exp_line(1, 0, 7); exp_line(1, 1, 7); exp_fd();
    wait_size(15, "t6_mid_line");
    mode = 1'b1;
    wait_size(9, "t6_src0_second_line");
    en1 = 1'b1;
    wait_size(0, "t6_drain");

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_conf_arbiter.md
Name: disp_conf_arbiter

Overview:
- Merges the disparity/confidence output streams of two pixel processor instances (src0 = left eye, src1 = right eye) into one output stream.
- Grants one source for a whole decimated line, then rearbitrates, so lines are never interleaved word-by-word.
- Tags every beat with source, start-of-line, end-of-line and start-of-frame, and signals frame completion when both sources have finished.
- Sits between the pixel processors and the frame writer.

Parameters:
- disp_bits, 5, disparity width; data word is disp_bits+8 bits ({disp, conf}).
- line_words, 320, words per decimated line per source (>=2).
- lines_per_frame, 240, lines per frame per source (>=1).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- mode  in  1  0 = strict alternation, 1 = work-conserving round-robin
- in0_data  in  disp_bits+8  src0 word
- in0_valid  in  1  src0 valid
- in0_ready  out  1  src0 ready
- in1_data  in  disp_bits+8  src1 word
- in1_valid  in  1  src1 valid
- in1_ready  out  1  src1 ready
- out_data  out  disp_bits+8  selected word
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready
- out_src  out  1  source of current beat
- out_sol  out  1  first beat of a line
- out_eol  out  1  last beat of a line
- out_sof  out  1  first beat of line 0 of a source's frame
- frame_done  out  1  one-cycle pulse when both sources finish a frame

Behaviour:
- Reset is asynchronous on reset_n low.
  - State = ARB, next-preference pointer = src0.
  - word_cnt, line_cnt0, line_cnt1, frame_done = 0.
  - All ready/valid/tag outputs are 0. out_data and out_src are 0.
- States and what they drive:
  - ARB: one bubble cycle per decision. No readies asserted, out_valid = 0.
  - GRANT0 / GRANT1: out_data = in_sel_data, out_valid = in_sel_valid, in_sel_ready = out_ready, unselected ready = 0. This path is combinational, zero latency, with no buffering.
- Beats: a beat is valid && ready on the granted source.
  - word_cnt increments per beat.
  - On the beat with word_cnt == line_words-1: word_cnt <= 0, that source's line_cnt increments, state <= ARB, pointer <= other source.
- Tags (combinational from counters while in GRANTx):
  - out_sol = (word_cnt == 0).
  - out_eol = (word_cnt == line_words-1).
  - out_sof = out_sol && (line_cnt_sel == 0).
  - out_src = granted index.
- A source is "done" when its line_cnt == lines_per_frame. A done source is never granted.
- ARB decision, evaluated each ARB cycle:
  - mode 0: grant the pointer source if it is not done, else the other source if it is not done. Input valids are ignored, so GRANT may idle waiting for valid.
  - mode 1: grant the pointer source if it is valid and not done; else the other source if it is valid and not done; else stay in ARB. The pointer is unchanged while staying.
- Frame completion: when both sources are done in ARB:
  - frame_done pulses for 1 cycle.
  - line_cnt0, line_cnt1 and the pointer clear, so the new frame starts with src0.
  - State stays ARB.
- mode is sampled only in ARB. A change mid-line takes effect at the next ARB.
- out_valid held with out_ready low: data and tags stay stable as long as the source holds (the source FIFO guarantees this).
- Reset mid-line: the partial line is discarded downstream. After release, the next grant starts a fresh frame at src0.
- Counters are sized as $clog2(line_words) and $clog2(lines_per_frame+1) bits.

Test Plan:
- Reset, mode 0, both sources always valid, out_ready = 1, line_words = 4, lines_per_frame = 2:
  - Beat order is src0 x4, bubble, src1 x4, bubble, src0 x4, bubble, src1 x4.
  - sol/eol assert on beats 1/4 of each line; sof only on each source's first line.
  - frame_done pulses in the ARB cycle after the last beat.
- mode 0, in1_valid = 0 during its turn: GRANT1 holds with out_valid = 0 and in0_ready = 0, even though src0 is valid. This continues until in1_valid rises.
- mode 1, src1 idle for 3 lines: src0 is granted for 2 consecutive lines, then becomes done and is not granted. src1 then receives 2 lines. frame_done fires only after src1's 2nd line.
- Backpressure: out_ready toggles 1,0,1,0 mid-line. Word count advances only on handshakes, out_data is stable while stalled, and no beat is lost or duplicated against the scoreboard.
- reset_n asserted after 2 beats of a src1 line: outputs go to 0 immediately, asynchronously. After release, the first beat is src0 with sol = 1 and sof = 1.
- mode switched 0 to 1 mid-line: the current line completes under GRANT unchanged, and the next ARB applies the mode-1 rule.
